// File: rtl/freq_gate_counter_if.sv
// Bus between the frequency measurement stage and its surroundings: the measured
// input, gate period programming and the published BCD digits for the display driver.
interface freq_gate_counter_if #(
  parameter int PERIOD_WIDTH = 12
);
  logic                    signal_in;
  logic [PERIOD_WIDTH-1:0] period;
  logic                    period_load;
  logic [3:0]              ten_count;
  logic [3:0]              unit_count;
  logic                    load;
  logic                    overflow;

  modport master (
    output signal_in, period, period_load,
    input  ten_count, unit_count, load, overflow
  );

  modport slave (
    input  signal_in, period, period_load,
    output ten_count, unit_count, load, overflow
  );
endinterface

// File: rtl/freq_gate_counter.sv
// Gate-window frequency counter: counts synchronized rising edges of signal_in into a
// saturating two-digit BCD counter and publishes the digits with a load strobe per frame.
module freq_gate_counter #(
  parameter int PERIOD_WIDTH   = 12,
  parameter int PERIOD_DEFAULT = 100
) (
  input  logic               clk,
  input  logic               reset,
  freq_gate_counter_if.slave bus
);
  typedef enum logic [1:0] {COUNT, PUBLISH, CLEAR} state_t;

  localparam logic [PERIOD_WIDTH-1:0] PERIOD_RESET = PERIOD_WIDTH'(PERIOD_DEFAULT);
  localparam logic [PERIOD_WIDTH-1:0] ONE          = PERIOD_WIDTH'(1);

  state_t                  state;
  state_t                  next_state;
  logic                    s1;
  logic                    s2;
  logic                    s3;
  logic                    rise;
  logic [PERIOD_WIDTH-1:0] pending_period;
  logic [PERIOD_WIDTH-1:0] active_period;
  logic [PERIOD_WIDTH-1:0] eff_period;
  logic [PERIOD_WIDTH-1:0] cyc;
  logic [3:0]              tens;
  logic [3:0]              units;
  logic                    sticky_ovf;
  logic                    last_cycle;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= bus.signal_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // s1 only resolves metastability; edges are taken from the settled s2/s3 pair.
  assign rise       = s2 & ~s3;
  assign eff_period = (active_period == '0) ? ONE : active_period;
  assign last_cycle = (cyc == eff_period - ONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= COUNT;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      COUNT:   if (last_cycle) next_state = PUBLISH;
      PUBLISH: next_state = CLEAR;
      CLEAR:   next_state = COUNT;
      default: next_state = COUNT;
    endcase
  end

  // A new gate length only takes effect at a frame boundary, never mid-window.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending_period <= PERIOD_RESET;
      active_period  <= PERIOD_RESET;
    end else begin
      if (bus.period_load) pending_period <= bus.period;
      if (state == CLEAR)  active_period  <= pending_period;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cyc        <= '0;
      tens       <= 4'd0;
      units      <= 4'd0;
      sticky_ovf <= 1'b0;
    end else begin
      case (state)
        COUNT: begin
          cyc <= cyc + ONE;
          if (rise) begin
            if (units == 4'd9) begin
              if (tens == 4'd9) begin
                sticky_ovf <= 1'b1;
              end else begin
                units <= 4'd0;
                tens  <= tens + 4'd1;
              end
            end else begin
              units <= units + 4'd1;
            end
          end
        end
        CLEAR: begin
          cyc        <= '0;
          tens       <= 4'd0;
          units      <= 4'd0;
          sticky_ovf <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.ten_count  <= 4'd0;
      bus.unit_count <= 4'd0;
      bus.overflow   <= 1'b0;
      bus.load       <= 1'b0;
    end else begin
      bus.load <= (state == PUBLISH);
      if (state == PUBLISH) begin
        bus.ten_count  <= tens;
        bus.unit_count <= units;
        bus.overflow   <= sticky_ovf;
      end
    end
  end
endmodule
